// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD conversion blocks.
//   BCD_DIGIT_W  : width of one packed BCD digit
//   bcd_digit_t  : one BCD digit
//   conv_state_t : state of the sequential converter
//   pow10(n)     : 10**n, saturated so that it always stays above any 32-bit value
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Once the running product passes 10^10 it already exceeds every 32-bit
  // input, so further multiplication is skipped to keep the result in 64 bits.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      if (r < 64'd10_000_000_000) r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
// Ports:
//   i_digit : BCD digit before adjustment
//   o_digit : adjusted digit (i_digit + 3 when i_digit >= 5)
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t i_digit,
  output bcd_digit_t o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) o_digit = i_digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary to packed-BCD converter (shift-and-add-3), one input bit
// per clock.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its data stable until then, and ready never
// depends on valid.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : upstream offers in
//   in_ready  : converter idle and able to accept
//   in        : unsigned binary value
//   out_valid : out/overflow valid, held until out_ready
//   out_ready : downstream takes the result
//   out       : packed BCD, least significant digit in bits [3:0]
//   overflow  : in >= 10^DIGITS (out then holds in mod 10^DIGITS)
//   dbg_state : current converter state
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out,
  output logic                  overflow,
  output conv_state_t           dbg_state
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CW    = $clog2(BIN_W + 1);
  localparam logic [CW-1:0] LAST   = CW'(BIN_W - 1);
  localparam logic [63:0]   OVF_TH = pow10(DIGITS);

  conv_state_t        r_state;
  logic [BIN_W-1:0]   r_shreg;
  logic [BCD_W-1:0]   r_bcd;
  logic [CW-1:0]      r_cnt;
  logic [BCD_W-1:0]   r_out;
  logic               r_ovf;
  logic               r_out_valid;

  logic [BCD_W-1:0]       w_adj;
  logic [BCD_W+BIN_W-1:0] w_cat;
  logic [BCD_W-1:0]       w_next_bcd;
  logic [BIN_W-1:0]       w_next_sh;
  logic                   w_ovf;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .i_digit (r_bcd[BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .o_digit (w_adj[BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

  // Whatever leaves the top digit is dropped, giving in mod 10^DIGITS.
  assign w_cat      = {w_adj, r_shreg} << 1;
  assign w_next_bcd = w_cat[BCD_W+BIN_W-1 -: BCD_W];
  assign w_next_sh  = w_cat[BIN_W-1:0];
  assign w_ovf      = (64'(in) >= OVF_TH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_shreg <= in;
            r_bcd   <= '0;
            r_cnt   <= '0;
            r_ovf   <= w_ovf;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_bcd   <= w_next_bcd;
          r_shreg <= w_next_sh;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_out       <= w_next_bcd;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign overflow  = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;
  import bcd_pkg::*;

  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;
  localparam int OW     = 4 * DIGITS;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [BIN_W-1:0]  bin_in   = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OW-1:0]     out;
  logic              overflow;
  conv_state_t       dbg_state;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (bin_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Decimal digits of v mod 10^DIGITS, packed four bits per digit.
  function automatic logic [OW-1:0] model_bcd(input int unsigned v);
    logic [OW-1:0] r;
    int unsigned   x;
    r = '0;
    x = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int unsigned limit_val();
    int unsigned l;
    l = 1;
    for (int k = 0; k < DIGITS; k++) l = l * 10;
    return l;
  endfunction

  // Plays the role of the downstream BCD-to-binary decoder.
  function automatic int unsigned bcd_decode(input logic [OW-1:0] b);
    int unsigned s;
    s = 0;
    for (int k = DIGITS - 1; k >= 0; k--) s = s * 10 + int'(b[4*k +: 4]);
    return s;
  endfunction

  function automatic bit digits_ok(input logic [OW-1:0] b);
    for (int k = 0; k < DIGITS; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [OW:0] exp_q[$];   // {overflow, bcd}
  int unsigned val_q[$];

  // ---------------- driver ----------------
  task automatic accept(input int unsigned v);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_before_accept", in_ready, 1'b1);
    in_valid = 1'b1;
    bin_in   = BIN_W'(v);
    exp_q.push_back({(v >= limit_val()), model_bcd(v)});
    val_q.push_back(v % limit_val());
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // One full conversion: accept, latency, result, optional stall, release.
  task automatic convert(input int unsigned v, input int stall, input bit poke);
    int          n;
    bit          rdy_seen;
    bit          held_ok;
    logic [OW:0] e;
    int unsigned ev;
    accept(v);
    // Already one negedge past T0 here.
    n = 1;
    rdy_seen = 1'b0;
    while (!out_valid && n < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n - 1), 64'(BIN_W));
    check("in_ready_low_in_shift", rdy_seen, 1'b0);
    e  = exp_q.pop_front();
    ev = val_q.pop_front();
    check("out", out, e[OW-1:0]);
    check("overflow", overflow, e[OW]);
    check("digits_le_9", digits_ok(out), 1'b1);
    check("decoded_value", 64'(bcd_decode(out)), 64'(ev));
    held_ok = 1'b1;
    if (poke) begin
      in_valid = 1'b1;
      bin_in   = BIN_W'(999);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (!out_valid || out !== e[OW-1:0] || overflow !== e[OW] || in_ready) held_ok = 1'b0;
    end
    if (stall > 0) check("held_in_done", held_ok, 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("out_valid_cleared", out_valid, 1'b0);
    check("in_ready_after_release", in_ready, 1'b1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit          seen;
    int unsigned v;
    int          ovf_checked;

    repeat (2) @(negedge clk);
    check("in_ready_during_rst", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out", out, '0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_state", dbg_state, IDLE);

    convert(0, 3, 1'b0);
    convert(1234, 0, 1'b0);
    convert(9999, 0, 1'b0);
    convert(16383, 0, 1'b0);
    convert(10000, 0, 1'b0);

    // Backpressure with a competing input held on in_valid.
    convert(42, 20, 1'b1);
    repeat (3) @(negedge clk);
    check("no_accept_during_hold", dbg_state, IDLE);

    // Reset in the middle of a conversion.
    accept(555);
    void'(exp_q.pop_back());
    void'(val_q.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready_during_mid_rst", in_ready, 1'b0);
    rst = 1'b0;
    check("mid_rst_state", dbg_state, IDLE);
    check("mid_rst_out", out, '0);
    seen = 1'b0;
    for (int i = 0; i < BIN_W + 6; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("no_out_valid_after_abort", seen, 1'b0);
    convert(77, 0, 1'b0);

    // Random sweep within range.
    for (int i = 0; i < 200; i++) begin
      v = $urandom_range(9999, 0);
      convert(v, $urandom_range(3, 0), 1'b0);
      check("sweep_no_overflow", overflow, 1'b0);
    end

    // Random values across the full input range, overflow included.
    ovf_checked = 0;
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range((1 << BIN_W) - 1, 0);
      convert(v, $urandom_range(2, 0), 1'b0);
      ovf_checked++;
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
